// File: rtl/sync_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// sync_pulse_gen_if
//   Seconds-timestamp handshake between the sample-counter stage (master)
//   and sync_pulse_gen (slave).
//
//   Handshake: the master presents sec with sec_vld; the slave raises
//   sec_ready only while it is idle. A transfer happens on a rising clk edge
//   where sec_vld && sec_ready. A sec_vld seen while sec_ready is low is not a
//   transfer: the value is dropped and the slave records an overrun.
//
//   Signals:
//     sec       [11:0]  seconds value to send       (master -> slave)
//     sec_vld           sec valid                   (master -> slave)
//     sec_ready         slave idle, can take a value (slave -> master)
// ---------------------------------------------------------------------------
interface sync_pulse_gen_if;
  logic [11:0] sec;
  logic        sec_vld;
  logic        sec_ready;

  modport master (output sec, output sec_vld, input sec_ready);
  modport slave  (input sec, input sec_vld, output sec_ready);
endinterface

// File: rtl/sync_pulse_gen.sv
// ---------------------------------------------------------------------------
// sync_pulse_gen
//   Builds the TTL sync sequence for the behaviour box from per-second
//   timestamps. Every accepted second gives a PULSE_TICKS-wide start pulse;
//   every BARCODE_EVERY-th accepted second (starting with the first after
//   reset) the pulse is followed by a gap, the 12-bit seconds value MSB first
//   and a stop slot. All durations are in acquisition frames (frame_pulse).
//
//   Optional feature: define SYNC_PARITY_EN to insert an even-parity slot
//   between the data bits and the stop slot.
//
//   Ports:
//     clk             system clock
//     rst             asynchronous active-high reset
//     frame_pulse     one-clk strobe per acquisition frame
//     sec_if          slave side of the seconds handshake (sec/sec_vld/sec_ready)
//     sync_pulse      registered sync line to the behaviour box
//     barcode_active  high from GAP through STOP of a barcoded sequence
//     overrun         sticky: sec_vld seen while not ready (cleared by rst)
//     state_dbg       current FSM state encoding
// ---------------------------------------------------------------------------
module sync_pulse_gen #(
  parameter int FS            = 25000,
  parameter int PULSE_MS      = 100,
  parameter int BIT_MS        = 10,
  parameter int BARCODE_EVERY = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_pulse,
  sync_pulse_gen_if.slave  sec_if,
  output logic             sync_pulse,
  output logic             barcode_active,
  output logic             overrun,
  output logic [2:0]       state_dbg
);

  localparam int TICKS_PER_MS = FS / 1000;
  localparam int PULSE_TICKS  = PULSE_MS * TICKS_PER_MS;
  localparam int BIT_TICKS    = BIT_MS * TICKS_PER_MS;
  localparam int MAX_TICKS    = (PULSE_TICKS > BIT_TICKS) ? PULSE_TICKS : BIT_TICKS;
  localparam int TW           = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int AW           = (BARCODE_EVERY > 1) ? $clog2(BARCODE_EVERY) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_GAP    = 3'd2,
    S_BITS   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tick_cnt;
  logic [TW-1:0]   tick_last;
  logic [3:0]      bit_cnt;
  logic [11:0]     shreg;
  logic            barcode;
  logic [AW-1:0]   acc_cnt;
  logic            xfer;
  logic            slot_done;
  logic            last_bit;
  logic            sync_nxt;
  logic            active_nxt;
`ifdef SYNC_PARITY_EN
  logic            parity;
`endif

  assign sec_if.sec_ready = (state == S_IDLE);
  assign state_dbg        = state;

  assign xfer      = sec_if.sec_vld && (state == S_IDLE);
  assign tick_last = (state == S_START) ? TW'(PULSE_TICKS - 1) : TW'(BIT_TICKS - 1);
  // A slot ends on the clk edge that samples its N-th frame tick; frame ticks
  // in IDLE (including the transfer cycle) never count.
  assign slot_done = frame_pulse && (state != S_IDLE) && (tick_cnt == tick_last);
  assign last_bit  = (bit_cnt == 4'd11);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (xfer) state_nxt = S_START;
      S_START:  if (slot_done) state_nxt = barcode ? S_GAP : S_IDLE;
      S_GAP:    if (slot_done) state_nxt = S_BITS;
      S_BITS: begin
        if (slot_done && last_bit) begin
`ifdef SYNC_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: if (slot_done) state_nxt = S_STOP;
      S_STOP:   if (slot_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, taken from the
  // state being entered so the line changes on the slot-ending edge.
  always_comb begin
    sync_nxt   = 1'b0;
    active_nxt = 1'b0;
    case (state_nxt)
      S_START: sync_nxt = 1'b1;
      S_GAP:   active_nxt = 1'b1;
      S_BITS: begin
        active_nxt = 1'b1;
        // The register shifts on this same edge when a bit slot ends, so the
        // next bit to show is one position down.
        sync_nxt = (state == S_BITS && slot_done) ? shreg[10] : shreg[11];
      end
      S_PARITY: begin
        active_nxt = 1'b1;
`ifdef SYNC_PARITY_EN
        sync_nxt = parity;
`endif
      end
      S_STOP:  active_nxt = 1'b1;
      default: begin
        sync_nxt   = 1'b0;
        active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pulse     <= 1'b0;
      barcode_active <= 1'b0;
    end else begin
      sync_pulse     <= sync_nxt;
      barcode_active <= active_nxt;
    end
  end

  // Datapath: tick counter, bit counter, shift register, accept counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      barcode  <= 1'b0;
      acc_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (state == S_IDLE || slot_done) tick_cnt <= '0;
      else if (frame_pulse)             tick_cnt <= tick_cnt + 1'b1;

      if (state == S_BITS) begin
        if (slot_done) bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        bit_cnt <= 4'd0;
      end

      if (xfer) begin
        shreg   <= sec_if.sec;
        barcode <= (acc_cnt == '0);
        acc_cnt <= (acc_cnt == AW'(BARCODE_EVERY - 1)) ? '0 : acc_cnt + 1'b1;
      end else if (state == S_BITS && slot_done) begin
        shreg <= {shreg[10:0], 1'b0};
      end

      if (sec_if.sec_vld && state != S_IDLE) overrun <= 1'b1;
    end
  end

`ifdef SYNC_PARITY_EN
  // Parity is taken at the transfer because the shift register is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       parity <= 1'b0;
    else if (xfer) parity <= ^sec_if.sec;
  end
`endif

endmodule

// File: tb/tb_sync_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_sync_pulse_gen
//   Directed bench for sync_pulse_gen with scaled timing: FS=1000, so one
//   frame tick per ms; PULSE_TICKS=6, BIT_TICKS=2, BARCODE_EVERY=10.
//   frame_pulse fires every 4 clk. Each frame tick seen while sec_ready is low
//   is logged as {barcode_active, sync_pulse} and compared with a stream
//   built from the value sent.
// ---------------------------------------------------------------------------
module tb_sync_pulse_gen;
  localparam int P  = 6;
  localparam int B  = 2;
  localparam int BE = 10;

  logic       clk;
  logic       rst;
  logic       frame_pulse;
  logic       sync_pulse;
  logic       barcode_active;
  logic       overrun;
  logic [2:0] state_dbg;

  sync_pulse_gen_if sec_if ();

  sync_pulse_gen #(
    .FS(1000), .PULSE_MS(P), .BIT_MS(B), .BARCODE_EVERY(BE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_pulse    (frame_pulse),
    .sec_if         (sec_if.slave),
    .sync_pulse     (sync_pulse),
    .barcode_active (barcode_active),
    .overrun        (overrun),
    .state_dbg      (state_dbg)
  );

  // clock / reset / frame strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int fcnt;
    fcnt = 0;
    frame_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fcnt = (fcnt + 1) % 4;
      frame_pulse = (fcnt == 3);
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  always @(negedge clk) begin
    if (frame_pulse && !sec_if.sec_ready) obs_q.push_back({barcode_active, sync_pulse});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [11:0] v, input logic bc);
    exp_q.delete();
    repeat (P) exp_q.push_back(2'b01);
    if (bc) begin
      repeat (B) exp_q.push_back(2'b10);
      for (int i = 11; i >= 0; i--) repeat (B) exp_q.push_back({1'b1, v[i]});
`ifdef SYNC_PARITY_EN
      repeat (B) exp_q.push_back({1'b1, ^v});
`endif
      repeat (B) exp_q.push_back(2'b10);
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    if (obs_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
  endtask

  // driver tasks
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!sec_if.sec_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, sec_if.sec_ready, 1);
  endtask

  task automatic send(input logic [11:0] v);
    @(negedge clk);
    sec_if.sec     = v;
    sec_if.sec_vld = 1'b1;
    @(posedge clk);
    #1;
    sec_if.sec_vld = 1'b0;
  endtask

  task automatic run_seq(input string tag, input logic [11:0] v, input logic bc);
    obs_q.delete();
    build_exp(v, bc);
    send(v);
    wait_ready(tag);
    compare_stream(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    sec_if.sec     = '0;
    sec_if.sec_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   sec_if.sec_ready, 1);
    check("rst_sync",    sync_pulse, 0);
    check("rst_active",  barcode_active, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state",   state_dbg, 0);
    rst = 1'b0;

    // first accepted second is barcoded, then a plain pulse
    run_seq("barcode_5a3", 12'h5A3, 1'b1);
    run_seq("plain_001", 12'h001, 1'b0);
    check("plain_overrun", overrun, 0);

    // cadence: barcodes on transfers 1, 11, 21
    do_reset();
    for (int i = 0; i <= 20; i++) run_seq($sformatf("cadence_%0d", i), 12'(i), (i % BE) == 0);
    check("cadence_overrun", overrun, 0);

    // overrun during START: value dropped, sequence unchanged
    do_reset();
    obs_q.delete();
    build_exp(12'h5A3, 1'b1);
    send(12'h5A3);
    repeat (6) @(posedge clk);
    #1;
    sec_if.sec     = 12'hFFF;
    sec_if.sec_vld = 1'b1;
    @(posedge clk);
    #1;
    sec_if.sec_vld = 1'b0;
    check("ovr_set", overrun, 1);
    wait_ready("ovr_seq");
    compare_stream("ovr_seq");
    run_seq("ovr_next", 12'h123, 1'b0);
    check("ovr_sticky", overrun, 1);

    // asynchronous reset in the middle of the data bits
    do_reset();
    check("rst2_overrun", overrun, 0);
    obs_q.delete();
    send(12'h5A3);
    n = 0;
    while (!(barcode_active && sync_pulse) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_bits_seen", sync_pulse, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_sync",   sync_pulse, 0);
    check("mid_rst_active", barcode_active, 0);
    check("mid_rst_ready",  sec_if.sec_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_seq("after_rst", 12'h00A, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
